// File: rtl/fp_util_pkg.sv
// Shared floating-point helpers: result classification type, class vector
// width and the packed-word width derivation used by the FP pipeline stages.
package fp_util_pkg;

   // Number of classification flags carried alongside each result
   localparam int CLASS_WIDTH = 4;

   // Classification of an IEEE-754 style value; all-zero means "normal"
   typedef struct packed {
      logic nan;
      logic inf;
      logic zero;
      logic sub;
   } fp_class_t;

   // Total width of a packed {sign, exponent, fraction} word
   function automatic int fp_width(input int exp_width, input int frac_width);
      return 1 + exp_width + frac_width;
   endfunction

endpackage

// File: rtl/fp_result_buffer_if.sv
// Data/handshake bundle of the result buffer: the valid-only capture side
// from the arithmetic unit and the valid/ready stream towards the consumer.
// Signal names are seen from the buffer (slave) side.
interface fp_result_buffer_if
   import fp_util_pkg::*;
#(
   parameter int EXP_WIDTH  = 8,
   parameter int FRAC_WIDTH = 23
);
   localparam int FP_WIDTH = fp_width(EXP_WIDTH, FRAC_WIDTH);

   logic [FP_WIDTH-1:0] fp_i;
   logic                valid_i;
   logic [FP_WIDTH-1:0] fp_o;
   fp_class_t           class_o;
   logic                valid_o;
   logic                ready_i;

   modport master (
      output fp_i, valid_i, ready_i,
      input  fp_o, class_o, valid_o
   );

   modport slave (
      input  fp_i, valid_i, ready_i,
      output fp_o, class_o, valid_o
   );

endinterface

// File: rtl/fp_classifier.sv
// Purely combinational classifier of a packed floating-point word into
// {nan, inf, zero, sub}. Sign is irrelevant to every class.
module fp_classifier
   import fp_util_pkg::*;
#(
   parameter int EXP_WIDTH  = 8,
   parameter int FRAC_WIDTH = 23
) (
   input  logic [EXP_WIDTH+FRAC_WIDTH:0] fp_i,
   output fp_class_t                     class_o
);
   logic [EXP_WIDTH-1:0]  exp_s;
   logic [FRAC_WIDTH-1:0] frac_s;
   logic                  exp_ones_s;
   logic                  exp_zero_s;
   logic                  frac_zero_s;
   logic                  sign_unused_s;

   assign sign_unused_s = fp_i[EXP_WIDTH+FRAC_WIDTH];

   // Decode exponent/fraction extremes and derive the class flags
   always_comb begin
      exp_s        = fp_i[EXP_WIDTH+FRAC_WIDTH-1:FRAC_WIDTH];
      frac_s       = fp_i[FRAC_WIDTH-1:0];
      exp_ones_s   = &exp_s;
      exp_zero_s   = ~|exp_s;
      frac_zero_s  = ~|frac_s;
      class_o.nan  = exp_ones_s & ~frac_zero_s;
      class_o.inf  = exp_ones_s &  frac_zero_s;
      class_o.zero = exp_zero_s &  frac_zero_s;
      class_o.sub  = exp_zero_s & ~frac_zero_s;
   end

endmodule

// File: rtl/fp_result_buffer.sv
// Captures every result from an upstream FP unit (no backpressure there),
// classifies it and buffers {class, value} in a first-word-fall-through FIFO
// drained over a valid/ready stream. Keeps sticky overflow and saturating
// NaN/infinity event counters, both cleared by clear_i.
module fp_result_buffer
   import fp_util_pkg::*;
#(
   parameter int EXP_WIDTH  = 8,
   parameter int FRAC_WIDTH = 23,
   parameter int DEPTH      = 4,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       clear_i,
   fp_result_buffer_if.slave          bus,
   output logic [$clog2(DEPTH+1)-1:0] level_o,
   output logic                       overflow_o,
   output logic [CNT_WIDTH-1:0]       nan_cnt_o,
   output logic [CNT_WIDTH-1:0]       inf_cnt_o
);
   localparam int FP_WIDTH    = fp_width(EXP_WIDTH, FRAC_WIDTH);
   localparam int ENTRY_WIDTH = CLASS_WIDTH + FP_WIDTH;
   localparam int IDX_WIDTH   = $clog2(DEPTH);
   localparam int PTR_WIDTH   = IDX_WIDTH + 1;
   localparam int LVL_WIDTH   = $clog2(DEPTH+1);

   logic [ENTRY_WIDTH-1:0] mem_r [DEPTH];
   logic [PTR_WIDTH-1:0]   wr_ptr_r;
   logic [PTR_WIDTH-1:0]   rd_ptr_r;
   logic                   overflow_r;
   logic [CNT_WIDTH-1:0]   nan_cnt_r;
   logic [CNT_WIDTH-1:0]   inf_cnt_r;

   fp_class_t              class_in_s;
   logic [ENTRY_WIDTH-1:0] head_s;
   logic [PTR_WIDTH-1:0]   level_s;
   logic                   empty_s;
   logic                   full_s;
   logic                   pop_s;
   logic                   push_s;
   logic                   drop_s;

   fp_classifier #(
      .EXP_WIDTH  (EXP_WIDTH),
      .FRAC_WIDTH (FRAC_WIDTH)
   ) u_classifier (
      .fp_i    (bus.fp_i),
      .class_o (class_in_s)
   );

   // Occupancy flags from the wrap-extended pointers and the push/pop/drop decision
   always_comb begin
      empty_s = (wr_ptr_r == rd_ptr_r);
      full_s  = (wr_ptr_r[IDX_WIDTH-1:0] == rd_ptr_r[IDX_WIDTH-1:0]) &&
                (wr_ptr_r[IDX_WIDTH] != rd_ptr_r[IDX_WIDTH]);
      level_s = wr_ptr_r - rd_ptr_r;
      pop_s   = ~empty_s & bus.ready_i;
      // At full a same-cycle pop frees the slot for the incoming result
      push_s  = bus.valid_i & (~full_s | pop_s);
      drop_s  = bus.valid_i & full_s & ~pop_s;
   end

   // Head presentation: value and class are forced to zero while empty
   always_comb begin
      head_s = mem_r[rd_ptr_r[IDX_WIDTH-1:0]];
      if (!empty_s) begin
         bus.fp_o    = head_s[FP_WIDTH-1:0];
         bus.class_o = fp_class_t'(head_s[ENTRY_WIDTH-1:FP_WIDTH]);
      end else begin
         bus.fp_o    = {FP_WIDTH{1'b0}};
         bus.class_o = fp_class_t'({CLASS_WIDTH{1'b0}});
      end
   end

   assign bus.valid_o = ~empty_s;
   assign level_o     = LVL_WIDTH'(level_s);
   assign overflow_o  = overflow_r;
   assign nan_cnt_o   = nan_cnt_r;
   assign inf_cnt_o   = inf_cnt_r;

   // FIFO storage and pointers; reset discards all buffered entries
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         wr_ptr_r <= {PTR_WIDTH{1'b0}};
         rd_ptr_r <= {PTR_WIDTH{1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {ENTRY_WIDTH{1'b0}};
         end
      end else begin
         if (push_s) begin
            mem_r[wr_ptr_r[IDX_WIDTH-1:0]] <= {class_in_s, bus.fp_i};
            wr_ptr_r <= wr_ptr_r + PTR_WIDTH'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_WIDTH'(1);
         end
      end
   end

   // Sticky overflow flag: set on a dropped result, clear_i has priority
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         overflow_r <= 1'b0;
      end else if (clear_i) begin
         overflow_r <= 1'b0;
      end else if (drop_s) begin
         overflow_r <= 1'b1;
      end else begin
         overflow_r <= overflow_r;
      end
   end

   // Saturating NaN/infinity counters over every strobed result, dropped ones included
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         nan_cnt_r <= {CNT_WIDTH{1'b0}};
         inf_cnt_r <= {CNT_WIDTH{1'b0}};
      end else if (clear_i) begin
         nan_cnt_r <= {CNT_WIDTH{1'b0}};
         inf_cnt_r <= {CNT_WIDTH{1'b0}};
      end else begin
         if (bus.valid_i && class_in_s.nan && (nan_cnt_r != {CNT_WIDTH{1'b1}})) begin
            nan_cnt_r <= nan_cnt_r + CNT_WIDTH'(1);
         end
         if (bus.valid_i && class_in_s.inf && (inf_cnt_r != {CNT_WIDTH{1'b1}})) begin
            inf_cnt_r <= inf_cnt_r + CNT_WIDTH'(1);
         end
      end
   end

endmodule
